huffman_build_ctrl: RTL and testbench
=====================================

Name: huffman_build_ctrl

Overview:
Sequencer that sits in front of the `huffman` table builder. On `start`, it reads the code-length memory and counts symbols per length (bl_count). It then computes the canonical next_code values and loads them into the builder by holding the builder's reset. It hands the length-memory port to the builder, then waits for the builder's `sig_end` and reports done or error. It owns the single length-memory read port and muxes it between its own count pass and the builder.

Parameters:
INDEX_BIT, 9, symbol index width in a length-memory word
LEN_BIT, 4, code-length field width (lengths 0..15)
COUNT_BIT, 9, half-width of each next_code lane (lane = 2*COUNT_BIT bits)
LEN_ADDRESS, 9, length-memory address width
INDEX_COUNT, 19, number of length entries to process

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to build a table
i_len_data  in  INDEX_BIT+LEN_BIT  length-memory read data {index, len}
o_len_address  out  LEN_ADDRESS  length-memory address (muxed)
len_ena  out  1  length-memory enable (muxed)
len_wea  out  1  length-memory write enable (muxed; always 0 from this block)
bld_len_address  in  LEN_ADDRESS  builder's address request
bld_len_ena  in  1  builder's enable request
bld_len_wea  in  1  builder's write request
next_code  out  16*2*COUNT_BIT  packed next_0..next_15, lane k = bits [k*18+17:k*18]
build_reset  out  1  drives builder reset
build_end  in  1  builder sig_end
busy  out  1  high from start accept until done
done  out  1  one-cycle completion pulse
err_oversub  out  1  sticky until next start: length set oversubscribed

Behaviour:
- Reset: state=IDLE; o_len_address=0; len_ena=0; len_wea=0; next_code=0; build_reset=1; busy=0; done=0; err_oversub=0; bl_count[*]=0.
- Reset mid-operation aborts any state and returns to IDLE with these values.
- Memory timing: `i_len_data` is valid on the 2nd rising edge after the edge that registers `o_len_address`. The block tracks this with a 2-stage valid shift register.
- IDLE: `start`=1 → CLEAR, busy=1, err_oversub=0. `start` is ignored while busy.
- CLEAR (1 cycle): bl_count[0..15]=0 → COUNT.
- COUNT (INDEX_COUNT cycles): issue addresses 0..INDEX_COUNT-1, one per cycle, with len_ena=1 and len_wea=0.
  - On each valid beat with len≠0, bl_count[len] += 1 (9-bit counters, no saturation needed).
  - After the last issue → DRAIN.
- DRAIN (2 cycles): len_ena=0; absorb the final two beats → CALC.
- CALC (15 cycles, k=1..15): bl_count[0] is treated as 0.
  - code_k = (code_{k-1} + bl_count[k-1]) << 1, with code_0=0 and 17-bit arithmetic.
  - Lane k = code_k zero-extended to 18 bits; lane 0 = 0.
  - Oversubscription: the 17-bit check code_k + bl_count[k] > 2^k sets err_oversub.
- After CALC: err_oversub=1 → DONE (builder never released); else → LOAD.
- LOAD (1 cycle): build_reset=1 with next_code stable, so the builder samples its next_* inputs → WAIT.
- WAIT: build_reset=0. The memory port is combinationally driven by bld_len_address/bld_len_ena/bld_len_wea. next_code is held. build_end=1 → DONE.
- DONE (1 cycle): done=1, busy=0, build_reset=1 → IDLE.
- build_reset=1 in every state except WAIT.
- In all states other than COUNT/DRAIN/WAIT: len_ena=0 and o_len_address holds its last value.
- All-zero lengths are legal: no error, the build runs (the builder writes nothing).
- An incomplete code (sum < 2^k) is legal.
- build_end asserted outside WAIT is ignored.
- Latency with no error: start → done = 1+19+2+15+1+WAIT+1 cycles.

Decomposition:
- Shared package `huffman_pkg`: LEN_BIT, INDEX_BIT, COUNT_BIT, MAX_LEN=15, state encoding constants, and the lane-slice macro/function for next_code.
- One sub-module, `huffman_next_code_calc`: holds bl_count, the serial 15-step next_code/oversubscription datapath and the next_code register, with count_clear/count_inc/len, calc_start and calc_done ports. The FSM and memory-port mux stay in the top.

Test Plan:
- RFC1951 example, entries 0..7 lengths {3,3,3,3,3,2,4,4}, rest 0 → bl_count[2]=1, [3]=5, [4]=2; lanes 1..5 = 0,0,2,14,32; err_oversub=0; builder released; done after build_end.
- Entries 0..2 length 1, rest 0 → err_oversub=1; build_reset never drops; done pulse 1+19+2+15+1 cycles after start.
- All 19 entries length 0 → all lanes 0, no error, WAIT entered, done follows build_end.
- Memory model with exact 2-edge read latency; check addresses 0..18 issued on consecutive cycles, len_wea=0 throughout, and bld_* mirrored on the port only during WAIT.
- `start` pulsed in COUNT and in WAIT → ignored; single done per accepted start.
- Reset asserted in the 10th COUNT cycle → next cycle IDLE with all outputs at reset values; a fresh start then gives the correct RFC result.

Source files
------------

// File: rtl/huffman_pkg.sv
// huffman_pkg: shared constants, state encoding and next_code lane helper
// for the Huffman table build sequencer.
//   INDEX_BIT/LEN_BIT  : {index, len} layout of a length-memory word
//   COUNT_BIT          : half-width of a next_code lane (lane = 2*COUNT_BIT)
//   LEN_ADDRESS        : length-memory address width
//   INDEX_COUNT        : number of length entries scanned per build
//   MAX_LEN            : longest code length (lanes 0..MAX_LEN)
package huffman_pkg;

  localparam int INDEX_BIT   = 32'sd9;
  localparam int LEN_BIT     = 32'sd4;
  localparam int COUNT_BIT   = 32'sd9;
  localparam int LEN_ADDRESS = 32'sd9;
  localparam int INDEX_COUNT = 32'sd19;
  localparam int MAX_LEN     = 32'sd15;

  localparam int LANE_COUNT  = MAX_LEN + 32'sd1;
  localparam int LANE_W      = 32'sd2 * COUNT_BIT;
  // Canonical code arithmetic runs one bit narrower than a lane.
  localparam int CODE_W      = LANE_W - 32'sd1;
  localparam int NEXT_CODE_W = LANE_COUNT * LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CALC  = 3'd4,
    ST_LOAD  = 3'd5,
    ST_WAIT  = 3'd6,
    ST_DONE  = 3'd7
  } build_state_t;

  // Lane k of the packed next_code bus (bits [k*LANE_W +: LANE_W]).
  function automatic logic [LANE_W-1:0] next_code_lane(
    input logic [NEXT_CODE_W-1:0] packed_codes,
    input logic [LEN_BIT-1:0]     k
  );
    next_code_lane = packed_codes[int'(k) * LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/huffman_next_code_calc.sv
// huffman_next_code_calc: per-length symbol counters plus the serial
// canonical next_code walk and oversubscription check.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   count_clear    : zero all bl_count entries
//   count_inc, len : one valid length beat; counts len when len != 0
//   calc_start     : begin the 15-step walk on the following cycles
//   calc_done      : high during the final (k = MAX_LEN) step cycle
//   calc_oversub   : oversubscription seen so far, including this step
//   next_code      : packed lanes 0..MAX_LEN (lane 0 is always 0)
module huffman_next_code_calc
  import huffman_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   count_clear,
  input  logic                   count_inc,
  input  logic [LEN_BIT-1:0]     len,
  input  logic                   calc_start,
  output logic                   calc_done,
  output logic                   calc_oversub,
  output logic [NEXT_CODE_W-1:0] next_code
);

  logic [COUNT_BIT-1:0]   bl_count_r [LANE_COUNT];
  logic [LEN_BIT-1:0]     step_r;
  logic                   running_r;
  logic                   oversub_r;
  logic [CODE_W-1:0]      code_r;
  logic [NEXT_CODE_W-1:0] next_code_r;

  logic [COUNT_BIT-1:0]   prev_count_s;
  logic [CODE_W-1:0]      sum_s;
  logic [CODE_W-1:0]      code_k_s;
  logic [CODE_W-1:0]      check_s;
  logic [CODE_W-1:0]      limit_s;
  logic                   step_over_s;

  // Symbols-per-length counters: cleared before a scan, bumped per nonzero length.
  always_ff @(posedge clock) begin
    if (reset || count_clear) begin
      for (int i = 32'sd0; i < LANE_COUNT; i++) begin
        bl_count_r[i] <= {COUNT_BIT{1'b0}};
      end
    end else if (count_inc && (len != {LEN_BIT{1'b0}})) begin
      bl_count_r[len] <= bl_count_r[len] + COUNT_BIT'(1'b1);
    end
  end

  // One canonical step: code_k from code_{k-1}; bl_count[0] never contributes.
  always_comb begin
    prev_count_s = {COUNT_BIT{1'b0}};
    if (step_r == LEN_BIT'(1'b1)) begin
      prev_count_s = {COUNT_BIT{1'b0}};
    end else begin
      prev_count_s = bl_count_r[step_r - LEN_BIT'(1'b1)];
    end
    sum_s       = code_r + CODE_W'(prev_count_s);
    code_k_s    = {sum_s[CODE_W-2:0], 1'b0};
    check_s     = code_k_s + CODE_W'(bl_count_r[step_r]);
    limit_s     = CODE_W'(1'b1) << step_r;
    step_over_s = running_r && (check_s > limit_s);
  end

  assign calc_done    = running_r && (step_r == LEN_BIT'(MAX_LEN));
  assign calc_oversub = oversub_r | step_over_s;
  assign next_code    = next_code_r;

  // Serial walk over k = 1..MAX_LEN, writing lane k on step k.
  always_ff @(posedge clock) begin
    if (reset) begin
      running_r   <= 1'b0;
      step_r      <= {LEN_BIT{1'b0}};
      code_r      <= {CODE_W{1'b0}};
      oversub_r   <= 1'b0;
      next_code_r <= {NEXT_CODE_W{1'b0}};
    end else if (calc_start) begin
      running_r <= 1'b1;
      step_r    <= LEN_BIT'(1'b1);
      code_r    <= {CODE_W{1'b0}};
      oversub_r <= 1'b0;
    end else if (running_r) begin
      next_code_r[int'(step_r) * LANE_W +: LANE_W] <= {1'b0, code_k_s};
      code_r    <= code_k_s;
      oversub_r <= oversub_r | step_over_s;
      if (calc_done) begin
        running_r <= 1'b0;
      end else begin
        step_r <= step_r + LEN_BIT'(1'b1);
      end
    end
  end

endmodule

// File: rtl/huffman_build_ctrl.sv
// huffman_build_ctrl: sequencer in front of the huffman table builder.
// Scans the length memory, derives canonical next_code values, loads them
// into the builder while holding its reset, then lends it the memory port.
// Ports:
//   clock, reset             : clock and synchronous active-high reset
//   start                    : one-cycle build request (ignored while busy)
//   i_len_data               : length-memory read data {index, len}
//   o_len_address/len_ena/len_wea : length-memory port (own scan or builder)
//   bld_len_address/ena/wea  : builder's port request, passed through in WAIT
//   next_code                : packed canonical start codes, lanes 0..15
//   build_reset              : builder reset, released only while waiting
//   build_end                : builder finished
//   busy, done, err_oversub  : status (done is a one-cycle pulse)
module huffman_build_ctrl
  import huffman_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [INDEX_BIT+LEN_BIT-1:0] i_len_data,
  output logic [LEN_ADDRESS-1:0]       o_len_address,
  output logic                         len_ena,
  output logic                         len_wea,
  input  logic [LEN_ADDRESS-1:0]       bld_len_address,
  input  logic                         bld_len_ena,
  input  logic                         bld_len_wea,
  output logic [NEXT_CODE_W-1:0]       next_code,
  output logic                         build_reset,
  input  logic                         build_end,
  output logic                         busy,
  output logic                         done,
  output logic                         err_oversub
);

  localparam logic [LEN_ADDRESS-1:0] LAST_ADDR = LEN_ADDRESS'(INDEX_COUNT - 32'sd1);

  build_state_t           state_r;
  logic [LEN_ADDRESS-1:0] addr_r;
  logic                   ena_r;
  // Read-latency tracker: a beat issued at edge E is consumed at edge E+2.
  logic                   valid1_r;
  logic                   valid2_r;
  logic                   drain_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   err_r;
  logic                   build_reset_r;

  logic                   count_clear_s;
  logic                   calc_start_s;
  logic                   calc_done_s;
  logic                   calc_oversub_s;
  logic                   len_index_unused_s;

  assign count_clear_s      = (state_r == ST_CLEAR);
  assign calc_start_s       = (state_r == ST_DRAIN) && drain_r;
  // Only the length field matters for counting.
  assign len_index_unused_s = ^i_len_data[INDEX_BIT+LEN_BIT-1:LEN_BIT];

  huffman_next_code_calc u_calc (
    .clock        (clock),
    .reset        (reset),
    .count_clear  (count_clear_s),
    .count_inc    (valid2_r),
    .len          (i_len_data[LEN_BIT-1:0]),
    .calc_start   (calc_start_s),
    .calc_done    (calc_done_s),
    .calc_oversub (calc_oversub_s),
    .next_code    (next_code)
  );

  // Memory port owner: the builder in WAIT, the scan registers otherwise.
  always_comb begin
    if (state_r == ST_WAIT) begin
      o_len_address = bld_len_address;
      len_ena       = bld_len_ena;
      len_wea       = bld_len_wea;
    end else begin
      o_len_address = addr_r;
      len_ena       = ena_r;
      len_wea       = 1'b0;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign err_oversub = err_r;
  assign build_reset = build_reset_r;

  // Build sequencer with registered status and scan-port outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      addr_r        <= {LEN_ADDRESS{1'b0}};
      ena_r         <= 1'b0;
      valid1_r      <= 1'b0;
      valid2_r      <= 1'b0;
      drain_r       <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      build_reset_r <= 1'b1;
    end else begin
      done_r   <= 1'b0;
      valid1_r <= 1'b0;
      valid2_r <= valid1_r;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
            err_r   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state_r  <= ST_COUNT;
          addr_r   <= {LEN_ADDRESS{1'b0}};
          ena_r    <= 1'b1;
          valid1_r <= 1'b1;
        end
        ST_COUNT: begin
          if (addr_r == LAST_ADDR) begin
            state_r <= ST_DRAIN;
            ena_r   <= 1'b0;
            drain_r <= 1'b0;
          end else begin
            addr_r   <= addr_r + LEN_ADDRESS'(1'b1);
            valid1_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_r) begin
            state_r <= ST_CALC;
          end else begin
            drain_r <= 1'b1;
          end
        end
        ST_CALC: begin
          err_r <= calc_oversub_s;
          if (calc_done_s) begin
            if (calc_oversub_s) begin
              // An oversubscribed set never releases the builder.
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          // Builder has sampled next_code under reset; release it.
          state_r       <= ST_WAIT;
          build_reset_r <= 1'b0;
        end
        ST_WAIT: begin
          if (build_end) begin
            state_r       <= ST_DONE;
            done_r        <= 1'b1;
            busy_r        <= 1'b0;
            build_reset_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r       <= ST_IDLE;
          build_reset_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_build_ctrl.sv
// Directed + randomized bench for huffman_build_ctrl with a 2-edge-latency
// length memory and a scripted builder.
module tb_huffman_build_ctrl;
  import huffman_pkg::*;

  logic         clock;
  logic         reset;
  logic         start;
  logic [12:0]  i_len_data;
  logic [8:0]   o_len_address;
  logic         len_ena;
  logic         len_wea;
  logic [8:0]   bld_len_address;
  logic         bld_len_ena;
  logic         bld_len_wea;
  logic [287:0] next_code;
  logic         build_reset;
  logic         build_end;
  logic         busy;
  logic         done;
  logic         err_oversub;

  logic [12:0]  mem [512];
  int           cur_len [19];
  int           checks_total;
  int           checks_passed;
  int           checks_failed;

  huffman_build_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .i_len_data      (i_len_data),
    .o_len_address   (o_len_address),
    .len_ena         (len_ena),
    .len_wea         (len_wea),
    .bld_len_address (bld_len_address),
    .bld_len_ena     (bld_len_ena),
    .bld_len_wea     (bld_len_wea),
    .next_code       (next_code),
    .build_reset     (build_reset),
    .build_end       (build_end),
    .busy            (busy),
    .done            (done),
    .err_oversub     (err_oversub)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: data for the address registered at edge E appears after E+1,
  // so the DUT sees it at E+2. Unread cycles return junk.
  always @(posedge clock) begin
    if (len_ena) i_len_data <= mem[o_len_address];
    else         i_len_data <= 13'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    bld_len_address = 9'($urandom);
    bld_len_ena     = 1'($urandom);
    bld_len_wea     = 1'($urandom);
    #1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 512; i++) mem[i] = 13'($urandom);
    for (int i = 0; i < 19; i++) mem[i] = {9'($urandom), 4'(cur_len[i])};
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ":port"}, {53'd0, o_len_address, len_ena, len_wea}, 64'd0);
    check({tag, ":ctl"}, {60'd0, build_reset, busy, done, err_oversub}, 64'b1000);
    check({tag, ":nc"}, 64'(next_code != 288'd0), 64'd0);
  endtask

  // Full build for cur_len[]; expectations come from a plain-arithmetic
  // canonical-code model. wait_len (>=3) is how long the builder runs.
  task automatic build_run(input string name, input int wait_len);
    int  bl [16];
    int  exp_lane [16];
    int  code;
    bit  exp_err;
    for (int k = 0; k < 16; k++) bl[k] = 0;
    for (int i = 0; i < 19; i++) if (cur_len[i] != 0) bl[cur_len[i]]++;
    code = 0;
    exp_err = 1'b0;
    exp_lane[0] = 0;
    for (int k = 1; k < 16; k++) begin
      code = ((code + bl[k-1]) * 2) % 131072;
      exp_lane[k] = code;
      if (((code + bl[k]) % 131072) > (1 << k)) exp_err = 1'b1;
    end

    load_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, ":accept"}, {60'd0, busy, done, err_oversub, build_reset}, 64'b1001);

    for (int i = 0; i < 19; i++) begin
      tick();
      check($sformatf("%s:scan%0d", name, i),
            {52'd0, len_ena, len_wea, build_reset, o_len_address},
            {52'd0, 1'b1, 1'b0, 1'b1, 9'(i)});
      start = (i == 5);
    end
    start = 1'b0;

    build_end = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      check($sformatf("%s:quiet%0d", name, i), {61'd0, len_ena, build_reset, done}, 64'b010);
    end
    build_end = 1'b0;

    tick();
    check({name, ":n38"}, {60'd0, done, busy, err_oversub, build_reset},
          {60'd0, exp_err, ~exp_err, exp_err, 1'b1});
    for (int k = 0; k < 16; k++)
      check($sformatf("%s:lane%0d", name, k), 64'(next_code_lane(next_code, 4'(k))),
            64'(exp_lane[k]));

    if (!exp_err) begin
      for (int w = 0; w < wait_len; w++) begin
        tick();
        check($sformatf("%s:wait%0d", name, w), {61'd0, build_reset, done, busy}, 64'b001);
        check($sformatf("%s:mux%0d", name, w), {53'd0, o_len_address, len_ena, len_wea},
              {53'd0, bld_len_address, bld_len_ena, bld_len_wea});
        start     = (w == 1);
        build_end = (w == wait_len - 1);
      end
      start = 1'b0;
      tick();
      build_end = 1'b0;
      check({name, ":done"}, {51'd0, done, busy, build_reset, len_ena, o_len_address},
            {51'd0, 1'b1, 1'b0, 1'b1, 1'b0, 9'd18});
      check({name, ":lane_hold"}, 64'(next_code_lane(next_code, 4'd5)), 64'(exp_lane[5]));
    end

    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("%s:idle%0d", name, i), {60'd0, done, busy, build_reset, err_oversub},
            {60'd0, 1'b0, 1'b0, 1'b1, exp_err});
    end
  endtask

  task automatic set_rfc();
    for (int i = 0; i < 19; i++) cur_len[i] = 0;
    cur_len[0] = 3; cur_len[1] = 3; cur_len[2] = 3; cur_len[3] = 3;
    cur_len[4] = 3; cur_len[5] = 2; cur_len[6] = 4; cur_len[7] = 4;
  endtask

  initial begin
    checks_total    = 0;
    checks_passed   = 0;
    checks_failed   = 0;
    reset           = 1'b1;
    start           = 1'b0;
    build_end       = 1'b0;
    bld_len_address = 9'd0;
    bld_len_ena     = 1'b0;
    bld_len_wea     = 1'b0;
    for (int i = 0; i < 19; i++) cur_len[i] = 0;
    load_mem();

    tick();
    tick();
    check_reset_state("por");
    reset = 1'b0;
    tick();
    check_reset_state("por_idle");

    // RFC 1951 example: lanes 1..5 = 0,0,2,14,32.
    set_rfc();
    build_run("rfc", 4);
    check("rfc_lane4", 64'(next_code_lane(next_code, 4'd4)), 64'd14);

    // Three length-1 codes: oversubscribed.
    for (int i = 0; i < 19; i++) cur_len[i] = 0;
    cur_len[0] = 1; cur_len[1] = 1; cur_len[2] = 1;
    build_run("over", 3);

    // All-zero lengths.
    for (int i = 0; i < 19; i++) cur_len[i] = 0;
    build_run("zero", 5);

    // Randomized length sets.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 19; i++) begin
        if ($urandom_range(0, 1) == 0) cur_len[i] = 0;
        else if ($urandom_range(0, 3) == 0) cur_len[i] = $urandom_range(1, 15);
        else cur_len[i] = $urandom_range(3, 8);
      end
      build_run($sformatf("rnd%0d", r), $urandom_range(3, 8));
    end

    // Reset during the 10th scan cycle, then a clean RFC build.
    set_rfc();
    build_run("pre", 3);
    load_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_addr", {55'd0, o_len_address}, 64'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("mid_rst");
    build_run("post", 4);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
